// File: rtl/game_evaluator.sv
// Tic-tac-toe win/draw detector: snapshots the board on start, scans the eight lines one per clock,
// reports the lowest-index winning line or a draw, and holds a sticky gameover flag until clear.
module game_evaluator (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] board,
  input  logic        start,
  input  logic        clear,
  output logic        busy,
  output logic        done,
  output logic        winner_valid,
  output logic        winner,
  output logic [2:0]  win_line,
  output logic        draw,
  output logic        gameover,
  output logic [3:0]  cell_count
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      state;
  logic [17:0] snap;
  logic [2:0]  idx;

  logic [3:0]  ia, ib, ic;
  logic [1:0]  ca, cb, cc;
  logic        line_win;

  function automatic logic [3:0] occupied(input logic [17:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (b[2*i +: 2] == 2'b01 || b[2*i +: 2] == 2'b10) n = n + 4'd1;
    end
    return n;
  endfunction

  always_comb begin
    ia = 4'd0;
    ib = 4'd1;
    ic = 4'd2;
    case (idx)
      3'd0: begin ia = 4'd0; ib = 4'd1; ic = 4'd2; end
      3'd1: begin ia = 4'd3; ib = 4'd4; ic = 4'd5; end
      3'd2: begin ia = 4'd6; ib = 4'd7; ic = 4'd8; end
      3'd3: begin ia = 4'd0; ib = 4'd3; ic = 4'd6; end
      3'd4: begin ia = 4'd1; ib = 4'd4; ic = 4'd7; end
      3'd5: begin ia = 4'd2; ib = 4'd5; ic = 4'd8; end
      3'd6: begin ia = 4'd0; ib = 4'd4; ic = 4'd8; end
      default: begin ia = 4'd2; ib = 4'd4; ic = 4'd6; end
    endcase
    ca = snap[{ia, 1'b0} +: 2];
    cb = snap[{ib, 1'b0} +: 2];
    cc = snap[{ic, 1'b0} +: 2];
    // Code 11 is treated as empty, so it can never form a winning line.
    line_win = (ca == cb) && (cb == cc) && (ca == 2'b01 || ca == 2'b10);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      snap         <= 18'd0;
      idx          <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      win_line     <= 3'd0;
      draw         <= 1'b0;
      gameover     <= 1'b0;
      cell_count   <= 4'd0;
    end else if (clear) begin
      state        <= IDLE;
      snap         <= 18'd0;
      idx          <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      win_line     <= 3'd0;
      draw         <= 1'b0;
      gameover     <= 1'b0;
      cell_count   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !gameover) begin
            snap         <= board;
            idx          <= 3'd0;
            busy         <= 1'b1;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            win_line     <= 3'd0;
            draw         <= 1'b0;
            cell_count   <= occupied(board);
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (line_win) begin
            winner_valid <= 1'b1;
            winner       <= (ca == 2'b10);
            win_line     <= idx;
            gameover     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= REPORT;
          end else if (idx != 3'd7) begin
            idx <= idx + 3'd1;
          end else begin
            draw     <= (cell_count == 4'd9);
            gameover <= (cell_count == 4'd9);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= REPORT;
          end
        end
        REPORT: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
